cpu_control_sequencer: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/cpu_control_sequencer_if.sv | 43 ++++
 rtl/ctrl_decode.sv | 87 ++++++++
 rtl/cpu_control_sequencer.sv | 116 +++++++++++
 tb/tb_cpu_control_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the CPU control sequencer and its opcode decoder.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_PUSH = 4'h5;
  localparam logic [3:0] OP_POP  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_STK = 2'b10;

  localparam logic [3:0] FS_PASS_B = 4'hF;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StFault
  } state_e;

  typedef enum logic [2:0] {
    NsFetch, NsExec, NsMem, NsHalt, NsFault
  } next_class_e;

  // Selects are held for the whole EXEC/MEM/WB interval; the flags say which
  // strobes fire in which phase and whether a WB phase follows.
  typedef struct packed {
    logic       ma;
    logic       mb;
    logic       cs;
    logic [1:0] md;
    logic [3:0] fs;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       addr_sel;
    logic       mem_we;
    logic       rw_exec;
    logic       rw_wb;
    logic       push_exec;
    logic       pop_exec;
    logic       pc_load_exec;
    logic       pc_load_zero;
    logic       pc_load_wb;
    logic       go_wb;
    logic       need_room;
    logic       need_data;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath/memory side (slave).
interface cpu_control_sequencer_if;

  logic        start;
  logic [15:0] inst;
  logic        zero;
  logic        mem_ready;
  logic        stack_full;
  logic        stack_empty;

  logic        MA;
  logic        MB;
  logic        CS;
  logic [1:0]  MD;
  logic [3:0]  FS;
  logic [2:0]  DA;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic        RW;
  logic        addr_sel;
  logic        mem_req;
  logic        mem_we;
  logic        stack_push;
  logic        stack_pop;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic        halted;
  logic        fault;

  modport master (
    input  start, inst, zero, mem_ready, stack_full, stack_empty,
    output MA, MB, CS, MD, FS, DA, AA, BA, RW, addr_sel, mem_req, mem_we,
           stack_push, stack_pop, ir_load, pc_inc, pc_load, halted, fault
  );

  modport slave (
    output start, inst, zero, mem_ready, stack_full, stack_empty,
    input  MA, MB, CS, MD, FS, DA, AA, BA, RW, addr_sel, mem_req, mem_we,
           stack_push, stack_pop, ir_load, pc_inc, pc_load, halted, fault
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction word to control word plus next-state class.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] inst,
  output ctrl_word_t  cw,
  output next_class_e ns_class
);

  always_comb begin
    cw       = '0;
    ns_class = NsFault;
    case (inst[15:12])
      OP_NOP: ns_class = NsFetch;
      OP_ALU: begin
        ns_class   = NsExec;
        cw.da      = inst[11:9];
        cw.aa      = inst[8:6];
        cw.ba      = inst[5:3];
        cw.fs      = {1'b0, inst[2:0]};
        cw.md      = MD_ALU;
        cw.rw_exec = 1'b1;
      end
      OP_LDI: begin
        ns_class   = NsExec;
        cw.mb      = 1'b1;
        cw.cs      = 1'b1;
        cw.fs      = FS_PASS_B;
        cw.rw_exec = 1'b1;
      end
      OP_LD: begin
        ns_class    = NsMem;
        cw.ma       = 1'b1;
        cw.addr_sel = 1'b1;
        cw.md       = MD_MEM;
        cw.rw_wb    = 1'b1;
        cw.go_wb    = 1'b1;
      end
      OP_ST: begin
        ns_class    = NsMem;
        cw.ma       = 1'b1;
        cw.addr_sel = 1'b1;
        cw.mem_we   = 1'b1;
      end
      OP_PUSH: begin
        ns_class     = NsExec;
        cw.push_exec = 1'b1;
        cw.need_room = 1'b1;
      end
      OP_POP: begin
        ns_class     = NsExec;
        cw.md        = MD_STK;
        cw.pop_exec  = 1'b1;
        cw.rw_wb     = 1'b1;
        cw.go_wb     = 1'b1;
        cw.need_data = 1'b1;
      end
      OP_JMP: begin
        ns_class        = NsExec;
        cw.pc_load_exec = 1'b1;
      end
      OP_JZ: begin
        ns_class        = NsExec;
        cw.pc_load_zero = 1'b1;
      end
      OP_CALL: begin
        // PC+1 goes to the stack through the B mux in the same cycle as the jump.
        ns_class        = NsExec;
        cw.mb           = 1'b1;
        cw.push_exec    = 1'b1;
        cw.pc_load_exec = 1'b1;
        cw.need_room    = 1'b1;
      end
      OP_RET: begin
        ns_class      = NsExec;
        cw.md         = MD_STK;
        cw.pop_exec   = 1'b1;
        cw.pc_load_wb = 1'b1;
        cw.go_wb      = 1'b1;
        cw.need_data  = 1'b1;
      end
      OP_HALT: ns_class = NsHalt;
      default: ns_class = NsFault;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM driving all datapath selects and strobes.
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  cpu_control_sequencer_if.master bus
);

  state_e      state_q, state_d;
  ctrl_word_t  cw_q, cw_d, dec_cw;
  next_class_e dec_class;
  logic        in_body;
  logic        stack_err;

  ctrl_decode u_decode (
    .inst     (bus.inst),
    .cw       (dec_cw),
    .ns_class (dec_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
    end
  end

  assign in_body   = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);
  assign stack_err = (dec_cw.need_room && bus.stack_full) ||
                     (dec_cw.need_data && bus.stack_empty);

  always_comb begin
    state_d        = state_q;
    cw_d           = cw_q;
    bus.MA         = 1'b0;
    bus.MB         = 1'b0;
    bus.CS         = 1'b0;
    bus.MD         = MD_ALU;
    bus.FS         = '0;
    bus.DA         = '0;
    bus.AA         = '0;
    bus.BA         = '0;
    bus.RW         = 1'b0;
    bus.addr_sel   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.stack_push = 1'b0;
    bus.stack_pop  = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.halted     = 1'b0;
    bus.fault      = 1'b0;

    if (in_body) begin
      bus.MA = cw_q.ma;
      bus.MB = cw_q.mb;
      bus.CS = cw_q.cs;
      bus.MD = cw_q.md;
      bus.FS = cw_q.fs;
      bus.DA = cw_q.da;
      bus.AA = cw_q.aa;
      bus.BA = cw_q.ba;
    end

    case (state_q)
      StIdle: begin
        if (bus.start) state_d = StFetch;
      end
      StFetch: begin
        bus.mem_req = 1'b1;
        bus.ir_load = bus.mem_ready;
        bus.pc_inc  = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        cw_d = dec_cw;
        case (dec_class)
          NsFetch: state_d = StFetch;
          NsExec:  state_d = StExec;
          NsMem:   state_d = StMem;
          NsHalt:  state_d = StHalt;
          default: state_d = StFault;
        endcase
        // A stack op that would over/underflow is refused before any strobe fires.
        if (stack_err) state_d = StFault;
      end
      StExec: begin
        bus.RW         = cw_q.rw_exec;
        bus.stack_push = cw_q.push_exec;
        bus.stack_pop  = cw_q.pop_exec;
        bus.pc_load    = cw_q.pc_load_exec || (cw_q.pc_load_zero && bus.zero);
        state_d        = cw_q.go_wb ? StWb : StFetch;
      end
      StMem: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = cw_q.mem_we;
        bus.addr_sel = cw_q.addr_sel;
        if (bus.mem_ready) state_d = cw_q.go_wb ? StWb : StFetch;
      end
      StWb: begin
        bus.RW      = cw_q.rw_wb;
        bus.pc_load = cw_q.pc_load_wb;
        state_d     = StFetch;
      end
      StHalt:  bus.halted = 1'b1;
      StFault: bus.fault  = 1'b1;
      default: state_d = StFault;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench: per-instruction expected output traces built from the instruction rules.
module tb_cpu_control_sequencer;

  typedef struct packed {
    logic       ma;
    logic       mb;
    logic       cs;
    logic [1:0] md;
    logic [3:0] fs;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic       rw;
    logic       addr_sel;
    logic       mem_req;
    logic       mem_we;
    logic       push;
    logic       pop;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       halted;
    logic       fault;
  } out_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  out_t exp_q[$];
  bit   rdy_q[$];
  bit   st_q[$];

  cpu_control_sequencer_if bus ();

  cpu_control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.ma = bus.MA;  o.mb = bus.MB;  o.cs = bus.CS;  o.md = bus.MD;  o.fs = bus.FS;
    o.da = bus.DA;  o.aa = bus.AA;  o.ba = bus.BA;  o.rw = bus.RW;
    o.addr_sel = bus.addr_sel;  o.mem_req = bus.mem_req;  o.mem_we = bus.mem_we;
    o.push = bus.stack_push;  o.pop = bus.stack_pop;  o.ir_load = bus.ir_load;
    o.pc_inc = bus.pc_inc;  o.pc_load = bus.pc_load;
    o.halted = bus.halted;  o.fault = bus.fault;
    return o;
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push_cyc(input out_t e, input bit rdy, input bit st);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    st_q.push_back(st);
  endtask

  // Runs the queued trace; entered and left 1 time unit after a rising edge.
  task automatic run_plan(input string tag);
    int   n;
    out_t e, got;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.mem_ready = rdy_q.pop_front();
      bus.start     = st_q.pop_front();
      @(negedge clk);
      got = sample();
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h, expected %h", tag, n, got, e);
      end
      n++;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic sticky_tail(input bit is_fault);
    out_t e;
    e = '0;
    e.fault  = is_fault;
    e.halted = !is_fault;
    for (int i = 0; i < 3; i++) push_cyc(e, rnd(), 1'b1);
  endtask

  // Expected trace of one instruction from the start of its FETCH.
  task automatic plan_inst(input logic [15:0] ins, input int fw, input int mw,
                           input bit z, input bit full, input bit empty, output bit term);
    out_t e, s;
    term = 1'b0;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1'b1;
      push_cyc(e, 1'b0, rnd());
    end
    e = '0; e.mem_req = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
    push_cyc(e, 1'b1, rnd());
    push_cyc('0, rnd(), rnd());
    s = '0;
    case (ins[15:12])
      4'h0: ;
      4'h1: begin
        s.da = ins[11:9]; s.aa = ins[8:6]; s.ba = ins[5:3]; s.fs = {1'b0, ins[2:0]};
        e = s; e.rw = 1'b1; push_cyc(e, rnd(), rnd());
      end
      4'h2: begin
        s.mb = 1'b1; s.cs = 1'b1; s.fs = 4'hF;
        e = s; e.rw = 1'b1; push_cyc(e, rnd(), rnd());
      end
      4'h3, 4'h4: begin
        s.ma = 1'b1;
        if (ins[15:12] == 4'h3) s.md = 2'b01;
        e = s; e.addr_sel = 1'b1; e.mem_req = 1'b1; e.mem_we = (ins[15:12] == 4'h4);
        for (int i = 0; i < mw; i++) push_cyc(e, 1'b0, rnd());
        push_cyc(e, 1'b1, rnd());
        if (ins[15:12] == 4'h3) begin
          e = s; e.rw = 1'b1; push_cyc(e, rnd(), rnd());
        end
      end
      4'h5: begin
        if (full) begin sticky_tail(1'b1); term = 1'b1; end
        else begin e = s; e.push = 1'b1; push_cyc(e, rnd(), rnd()); end
      end
      4'h6: begin
        if (empty) begin sticky_tail(1'b1); term = 1'b1; end
        else begin
          s.md = 2'b10;
          e = s; e.pop = 1'b1; push_cyc(e, rnd(), rnd());
          e = s; e.rw = 1'b1;  push_cyc(e, rnd(), rnd());
        end
      end
      4'h7: begin e = s; e.pc_load = 1'b1; push_cyc(e, rnd(), rnd()); end
      4'h8: begin e = s; e.pc_load = z;    push_cyc(e, rnd(), rnd()); end
      4'h9: begin
        if (full) begin sticky_tail(1'b1); term = 1'b1; end
        else begin
          s.mb = 1'b1;
          e = s; e.push = 1'b1; e.pc_load = 1'b1; push_cyc(e, rnd(), rnd());
        end
      end
      4'hA: begin
        if (empty) begin sticky_tail(1'b1); term = 1'b1; end
        else begin
          s.md = 2'b10;
          e = s; e.pop = 1'b1;     push_cyc(e, rnd(), rnd());
          e = s; e.pc_load = 1'b1; push_cyc(e, rnd(), rnd());
        end
      end
      4'hF: begin sticky_tail(1'b0); term = 1'b1; end
      default: begin sticky_tail(1'b1); term = 1'b1; end
    endcase
  endtask

  task automatic do_inst(input string tag, input logic [15:0] ins, input int fw, input int mw,
                         input bit z, input bit full, input bit empty, output bit term);
    bus.inst        = ins;
    bus.zero        = z;
    bus.stack_full  = full;
    bus.stack_empty = empty;
    plan_inst(ins, fw, mw, z, full, empty, term);
    run_plan(tag);
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    rst = 1'b1;
    bus.mem_ready = rnd();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.stack_full  = 1'b0;
    bus.stack_empty = 1'b0;
  endtask

  task automatic do_start(input string tag);
    push_cyc('0, rnd(), 1'b1);
    run_plan(tag);
  endtask

  task automatic test_reset();
    do_reset();
    // Idle must hold without start regardless of mem_ready.
    for (int i = 0; i < 3; i++) push_cyc('0, rnd(), 1'b0);
    run_plan("reset_idle");
  endtask

  task automatic test_alu();
    bit t;
    do_reset();
    do_start("alu_start");
    do_inst("alu_1a5a", 16'h1A5A, 0, 0, 1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic test_ld_wait();
    bit t;
    do_reset();
    do_start("ld_start");
    do_inst("ld_3123_wait2", 16'h3123, 0, 2, 1'b0, 1'b0, 1'b0, t);
    do_inst("st_wait", 16'h4000 | 16'($urandom_range(0, 4095)), 1, 1, 1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic test_call();
    bit t;
    do_reset();
    do_start("call_start");
    do_inst("call_ok", 16'h9040, 0, 0, 1'b0, 1'b0, 1'b0, t);
    do_inst("call_full", 16'h9040, 0, 0, 1'b0, 1'b1, 1'b0, t);
  endtask

  task automatic test_jz();
    bit t;
    do_reset();
    do_start("jz_start");
    do_inst("jz_z0", 16'h8010, 0, 0, 1'b0, 1'b0, 1'b0, t);
    do_inst("jz_z1", 16'h8010, 0, 0, 1'b1, 1'b0, 1'b0, t);
  endtask

  task automatic test_sticky();
    bit t;
    do_reset();
    do_start("illegal_start");
    do_inst("illegal_c", 16'hC123, 0, 0, 1'b0, 1'b0, 1'b0, t);
    do_reset();
    push_cyc('0, rnd(), 1'b0);
    run_plan("fault_cleared");
    do_start("halt_start");
    do_inst("halt_f000", 16'hF000, 1, 0, 1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic test_reset_mid_fetch();
    out_t e, got;
    do_reset();
    do_start("midfetch_start");
    e = '0; e.mem_req = 1'b1;
    push_cyc(e, 1'b0, 1'b0);
    run_plan("midfetch_wait");
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    got = sample();
    tests++;
    if (got.mem_req !== 1'b1) begin
      fails++;
      $display("FAIL midfetch_req_before_edge: got %b, expected 1", got.mem_req);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) push_cyc('0, rnd(), 1'b0);
    run_plan("midfetch_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [9];
    bit t;
    prog = '{16'h0000, 16'h1E3D, 16'h2ABC, 16'h4777, 16'h5000, 16'h6000, 16'h7123,
             16'hA000, 16'h3FFF};
    do_reset();
    do_start("b2b_start");
    foreach (prog[i]) do_inst($sformatf("b2b_%0d", i), prog[i], 0, 0, 1'b1, 1'b0, 1'b0, t);
  endtask

  task automatic test_random();
    bit t;
    logic [15:0] ins;
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      do_start("rand_start");
      for (int k = 0; k < 10; k++) begin
        ins = 16'($urandom);
        do_inst($sformatf("rand_e%0d_i%0d_%h", ep, k, ins), ins,
                $urandom_range(0, 2), $urandom_range(0, 2), rnd(),
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, t);
        if (t) break;
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.inst = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    bus.stack_full = 1'b0;
    bus.stack_empty = 1'b0;
    test_reset();
    test_alu();
    test_ld_wait();
    test_call();
    test_jz();
    test_sticky();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
